r4_sdf_sequencer: RTL

Control sequencer for one radix-4 single-path delay-feedback (SDF) stage of the 5G NR IFFT pipeline. It counts accepted input samples and decodes the count into fill, butterfly and drain commands for the stage's three delay lines and butterfly. It also produces the output-branch index and twiddle ROM address, and drains the stage after the last frame. One instance sits beside each radix-4 stage datapath; the stage's delay length is set by parameter.

---
 rtl/r4_sdf_sequencer_if.sv | 33 +++
 rtl/r4_sdf_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/r4_sdf_sequencer_if.sv
// Sample-strobe and command/branch bus between a radix-4 SDF stage datapath and its sequencer.
// Latency: none, wires only.
// Backpressure: none; the source presents samples and the sequencer never stalls it.
interface r4_sdf_sequencer_if #(
    parameter int ADDR_W = 12
) ();
    logic              in_valid;
    logic              in_last;
    logic              fill_en;
    logic              bf_en;
    logic              drain_en;
    logic [1:0]        sel_phase;
    logic [ADDR_W-1:0] sel_idx;
    logic [1:0]        out_branch;
    logic [ADDR_W-1:0] tw_addr;
    logic              out_valid;
    logic              busy;
    logic              frame_err;

    // Datapath / stimulus side: drives samples, observes commands.
    modport master (
        output in_valid, in_last,
        input  fill_en, bf_en, drain_en, sel_phase, sel_idx,
        input  out_branch, tw_addr, out_valid, busy, frame_err
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_last,
        output fill_en, bf_en, drain_en, sel_phase, sel_idx,
        output out_branch, tw_addr, out_valid, busy, frame_err
    );
endinterface

// File: rtl/r4_sdf_sequencer.sv
// Radix-4 SDF stage sequencer: decodes the accepted-sample count into fill/butterfly/drain commands and twiddle addresses.
// Latency: 1 cycle, so every output is registered and describes the sample or drain step taken at the previous edge.
// Backpressure: none; in_valid gaps stall the count, and samples that arrive during the 3L-cycle flush are dropped with frame_err.
// Optional twiddle multiplier: define R4_SEQ_TWIDDLE_EN; undefined ties tw_addr to 0 (last stage, unity twiddles).
module r4_sdf_sequencer #(
    parameter int N      = 2048,
    parameter int L      = 512,
    parameter int ADDR_W = 12
) (
    input  logic                clk,
    input  logic                rst,
    r4_sdf_sequencer_if.slave   sif
);

    localparam int                LW         = $clog2(L);
    localparam logic [ADDR_W-1:0] L_MASK     = ADDR_W'(L - 1);
    localparam logic [ADDR_W-1:0] POS_LAST   = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] FLUSH_LAST = ADDR_W'(3 * L - 1);

`ifdef R4_SEQ_TWIDDLE_EN
    localparam int PW     = 2 * ADDR_W + 2;
    localparam int STRIDE = N / (4 * L);
    logic [PW-1:0] prod;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic              primed_q, primed_d;
    logic [ADDR_W-1:0] fcnt_q, fcnt_d;

    logic              fill_en_q, fill_en_d;
    logic              bf_en_q, bf_en_d;
    logic              drain_en_q, drain_en_d;
    logic [1:0]        sel_phase_q, sel_phase_d;
    logic [ADDR_W-1:0] sel_idx_q, sel_idx_d;
    logic [1:0]        out_branch_q, out_branch_d;
    logic [ADDR_W-1:0] tw_addr_q, tw_addr_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              frame_err_q, frame_err_d;

    logic [1:0]        run_phase;
    logic [ADDR_W-1:0] run_idx;
    logic              step_taken;

    // Next-state and next-output decode for accepted samples and drain steps.
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        primed_d     = primed_q;
        fcnt_d       = fcnt_q;
        fill_en_d    = 1'b0;
        bf_en_d      = 1'b0;
        drain_en_d   = 1'b0;
        out_valid_d  = 1'b0;
        frame_err_d  = 1'b0;
        sel_phase_d  = sel_phase_q;
        sel_idx_d    = sel_idx_q;
        out_branch_d = out_branch_q;
        tw_addr_d    = tw_addr_q;
        busy_d       = (state_q != ST_IDLE);
        step_taken   = 1'b0;
        run_phase    = 2'(pos_q >> LW);
        run_idx      = pos_q & L_MASK;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (sif.in_valid) begin
                    step_taken  = 1'b1;
                    state_d     = ST_RUN;
                    sel_phase_d = run_phase;
                    sel_idx_d   = run_idx;
                    if (run_phase == 2'd3) begin
                        bf_en_d      = 1'b1;
                        out_valid_d  = 1'b1;
                        out_branch_d = 2'd0;
                        // Once a full butterfly group has been seen the delay lines hold results to emit.
                        if (run_idx == L_MASK) begin
                            primed_d = 1'b1;
                        end
                    end else begin
                        fill_en_d    = 1'b1;
                        out_valid_d  = primed_q;
                        out_branch_d = primed_q ? (run_phase + 2'd1) : 2'd0;
                    end
                    if (sif.in_last) begin
                        if (pos_q == POS_LAST) begin
                            state_d = ST_FLUSH;
                            fcnt_d  = '0;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                    pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                step_taken   = 1'b1;
                drain_en_d   = 1'b1;
                out_valid_d  = 1'b1;
                sel_phase_d  = 2'(fcnt_q >> LW);
                sel_idx_d    = fcnt_q & L_MASK;
                out_branch_d = 2'(fcnt_q >> LW) + 2'd1;
                frame_err_d  = sif.in_valid;
                if (fcnt_q == FLUSH_LAST) begin
                    state_d  = ST_IDLE;
                    pos_d    = '0;
                    primed_d = 1'b0;
                    fcnt_d   = '0;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                pos_d    = '0;
                primed_d = 1'b0;
                fcnt_d   = '0;
            end
        endcase

`ifdef R4_SEQ_TWIDDLE_EN
        prod = PW'(out_branch_d) * PW'(sel_idx_d) * PW'(STRIDE);
        if (step_taken) begin
            tw_addr_d = out_valid_d ? ADDR_W'(prod & PW'(N - 1)) : '0;
        end
`else
        if (step_taken) begin
            tw_addr_d = '0;
        end
`endif
    end

    // State and registered outputs; reset aborts any frame or flush in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pos_q        <= '0;
            primed_q     <= 1'b0;
            fcnt_q       <= '0;
            fill_en_q    <= 1'b0;
            bf_en_q      <= 1'b0;
            drain_en_q   <= 1'b0;
            sel_phase_q  <= '0;
            sel_idx_q    <= '0;
            out_branch_q <= '0;
            tw_addr_q    <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            primed_q     <= primed_d;
            fcnt_q       <= fcnt_d;
            fill_en_q    <= fill_en_d;
            bf_en_q      <= bf_en_d;
            drain_en_q   <= drain_en_d;
            sel_phase_q  <= sel_phase_d;
            sel_idx_q    <= sel_idx_d;
            out_branch_q <= out_branch_d;
            tw_addr_q    <= tw_addr_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign sif.fill_en    = fill_en_q;
    assign sif.bf_en      = bf_en_q;
    assign sif.drain_en   = drain_en_q;
    assign sif.sel_phase  = sel_phase_q;
    assign sif.sel_idx    = sel_idx_q;
    assign sif.out_branch = out_branch_q;
    assign sif.tw_addr    = tw_addr_q;
    assign sif.out_valid  = out_valid_q;
    assign sif.busy       = busy_q;
    assign sif.frame_err  = frame_err_q;

endmodule
